// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bundle: pipeline control, instruction-memory handshake and fetched-instruction outputs.
// master = fetch unit, slave = surrounding pipeline/memory environment.
interface pc_fetch_unit_if;
  logic        stall;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc4;

  modport master (
    input  stall, jump, jump_target, branch_taken, branch_target,
    input  imem_ready, imem_rdata,
    output imem_req, imem_addr,
    output instr_valid, instr, instr_pc, pc4
  );

  modport slave (
    output stall, jump, jump_target, branch_taken, branch_target,
    output imem_ready, imem_rdata,
    input  imem_req, imem_addr,
    input  instr_valid, instr, instr_pc, pc4
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC sequencer + instruction fetch: captured instruction visible one cycle after imem handshake.
// stall parks the FSM in HOLD (no request, outputs held); redirects override stall and squash data.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst_n,
  pc_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_AL   = RESET_PC & PC_ALIGN_MASK;

  state_e      state_q, state_d;
  logic        run_q, run_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        instr_valid_q, instr_valid_d;

  logic        redirect;
  logic        handshake;
  logic [31:0] redirect_target;
  logic [31:0] pc_inc;

  // run_q marks the edge that sampled reset release; INIT is the cycle that follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      run_q         <= 1'b0;
      pc_q          <= RESET_PC_AL;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      pc4_q         <= 32'h0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      pc4_q         <= pc4_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    run_d         = 1'b1;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    pc4_d         = pc4_q;
    instr_valid_d = instr_valid_q;

    pc_inc          = pc_q + 32'd4;
    redirect        = (state_q != INIT) && (bus.jump || bus.branch_taken);
    handshake       = (state_q == FETCH) && bus.imem_ready;
    redirect_target = bus.jump ? (bus.jump_target & PC_ALIGN_MASK)
                               : (bus.branch_target & PC_ALIGN_MASK);

    case (state_q)
      INIT:    if (run_q) state_d = FETCH;
      FETCH:   state_d = bus.stall ? HOLD : FETCH;
      HOLD:    state_d = bus.stall ? HOLD : FETCH;
      default: state_d = INIT;
    endcase

    // Redirect wins over a same-cycle handshake: the returned word belongs to the wrong path.
    if (redirect) begin
      pc_d          = redirect_target;
      instr_valid_d = 1'b0;
    end else if (handshake) begin
      instr_d       = bus.imem_rdata;
      instr_pc_d    = pc_q;
      pc4_d         = pc_inc;
      instr_valid_d = 1'b1;
      pc_d          = pc_inc;
    end else if (state_q == FETCH) begin
      instr_valid_d = 1'b0;
    end
  end

  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc4         = pc4_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: default-reset instance plus a RESET_PC=FFFFFFFC instance.
module tb_pc_fetch_unit;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  pc_fetch_unit_if bus ();
  pc_fetch_unit_if bus2 ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;

  // Memory returns the address xor a salt so each captured word is distinguishable.
  always_comb bus.imem_rdata = bus.imem_addr ^ SALT;
  always_comb bus2.imem_rdata = bus2.imem_addr ^ SALT;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h want=0", bus.imem_req); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", bus.instr_valid); end
    total++; if (bus.instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%0h want=0", bus.instr); end
    total++; if (bus.instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc got=%0h want=0", bus.instr_pc); end
    total++; if (bus.pc4 !== 32'h0) begin bad++; $display("FAIL rst_pc4 got=%0h want=0", bus.pc4); end
    total++; if (bus2.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL rst_addr2 got=%0h want=fffffffc", bus2.imem_addr); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL init_req got=%0h want=0", bus.imem_req); end
    step();
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%0h want=1", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr got=%0h want=0", bus.imem_addr); end
    total++; if (bus2.imem_req !== 1'b1) begin bad++; $display("FAIL first_req2 got=%0h want=1", bus2.imem_req); end
  endtask

  task automatic test_sequential();
    bus.imem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.imem_addr !== 32'(4 * k)) begin bad++; $display("FAIL seq_addr k=%0d got=%0h want=%0h", k, bus.imem_addr, 4 * k); end
      step();
      total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL seq_valid k=%0d got=%0h want=1", k, bus.instr_valid); end
      total++; if (bus.instr_pc !== 32'(4 * k)) begin bad++; $display("FAIL seq_instr_pc k=%0d got=%0h want=%0h", k, bus.instr_pc, 4 * k); end
      total++; if (bus.pc4 !== 32'(4 * k + 4)) begin bad++; $display("FAIL seq_pc4 k=%0d got=%0h want=%0h", k, bus.pc4, 4 * k + 4); end
      total++; if (bus.instr !== (32'(4 * k) ^ SALT)) begin bad++; $display("FAIL seq_instr k=%0d got=%0h want=%0h", k, bus.instr, 32'(4 * k) ^ SALT); end
    end
  endtask

  task automatic test_wait_ready();
    bus.imem_ready = 1'b0;
    bus.jump = 1'b1;
    bus.jump_target = 32'd100;
    step();
    bus.jump = 1'b0;
    total++; if (bus.imem_addr !== 32'd100) begin bad++; $display("FAIL wait_jump_addr got=%0h want=64", bus.imem_addr); end
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (bus.imem_addr !== 32'd100) begin bad++; $display("FAIL wait_addr k=%0d got=%0h want=64", k, bus.imem_addr); end
      total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL wait_valid k=%0d got=%0h want=0", k, bus.instr_valid); end
    end
    bus.imem_ready = 1'b1;
    step();
    total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL wait_cap_valid got=%0h want=1", bus.instr_valid); end
    total++; if (bus.instr_pc !== 32'd100) begin bad++; $display("FAIL wait_cap_pc got=%0h want=64", bus.instr_pc); end
    total++; if (bus.pc4 !== 32'd104) begin bad++; $display("FAIL wait_cap_pc4 got=%0h want=68", bus.pc4); end
    total++; if (bus.imem_addr !== 32'd104) begin bad++; $display("FAIL wait_next_addr got=%0h want=68", bus.imem_addr); end
  endtask

  task automatic test_redirect();
    bus.jump = 1'b1;
    bus.jump_target = 32'h0040_0003;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h0000_1000;
    step();
    total++; if (bus.imem_addr !== 32'h0040_0000) begin bad++; $display("FAIL jmp_addr got=%0h want=400000", bus.imem_addr); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL jmp_valid got=%0h want=0", bus.instr_valid); end
    total++; if (bus.instr_pc !== 32'd100) begin bad++; $display("FAIL jmp_discard got=%0h want=64", bus.instr_pc); end
    bus.jump = 1'b0;
    bus.branch_target = 32'h0000_0203;
    step();
    bus.branch_taken = 1'b0;
    total++; if (bus.imem_addr !== 32'h0000_0200) begin bad++; $display("FAIL br_addr got=%0h want=200", bus.imem_addr); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL br_valid got=%0h want=0", bus.instr_valid); end
  endtask

  task automatic test_stall();
    bus.imem_ready = 1'b0;
    bus.jump = 1'b1;
    bus.jump_target = 32'h0;
    step();
    bus.jump = 1'b0;
    bus.imem_ready = 1'b1;
    step();
    step();
    total++; if (bus.imem_addr !== 32'd8) begin bad++; $display("FAIL stall_pre_addr got=%0h want=8", bus.imem_addr); end
    bus.stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req k=%0d got=%0h want=0", k, bus.imem_req); end
      total++; if (bus.instr_pc !== 32'd8) begin bad++; $display("FAIL stall_pc k=%0d got=%0h want=8", k, bus.instr_pc); end
      total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid k=%0d got=%0h want=1", k, bus.instr_valid); end
    end
    bus.stall = 1'b0;
    step();
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL resume_req got=%0h want=1", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'd12) begin bad++; $display("FAIL resume_addr got=%0h want=c", bus.imem_addr); end
    step();
    total++; if (bus.instr_pc !== 32'd12) begin bad++; $display("FAIL resume_pc got=%0h want=c", bus.instr_pc); end
  endtask

  task automatic test_redirect_stall();
    bus.stall = 1'b1;
    bus.jump = 1'b1;
    bus.jump_target = 32'h0000_0040;
    step();
    bus.jump = 1'b0;
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rs_req got=%0h want=0", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'h40) begin bad++; $display("FAIL rs_addr got=%0h want=40", bus.imem_addr); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rs_valid got=%0h want=0", bus.instr_valid); end
    bus.stall = 1'b0;
    step();
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rs_resume_req got=%0h want=1", bus.imem_req); end
    step();
    total++; if (bus.instr_pc !== 32'h40) begin bad++; $display("FAIL rs_cap_pc got=%0h want=40", bus.instr_pc); end
  endtask

  task automatic test_wrap();
    bus2.imem_ready = 1'b1;
    step();
    bus2.imem_ready = 1'b0;
    total++; if (bus2.instr_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%0h want=fffffffc", bus2.instr_pc); end
    total++; if (bus2.pc4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%0h want=0", bus2.pc4); end
    total++; if (bus2.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%0h want=0", bus2.imem_addr); end
    total++; if (bus2.instr_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%0h want=1", bus2.instr_valid); end
  endtask

  task automatic test_mid_reset();
    bus.imem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL mr_req got=%0h want=0", bus.imem_req); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL mr_valid got=%0h want=0", bus.instr_valid); end
    total++; if (bus.instr_pc !== 32'h0) begin bad++; $display("FAIL mr_instr_pc got=%0h want=0", bus.instr_pc); end
    total++; if (bus.instr !== 32'h0) begin bad++; $display("FAIL mr_instr got=%0h want=0", bus.instr); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL mr_addr got=%0h want=0", bus.imem_addr); end
    step();
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL mr_nocap got=%0h want=0", bus.instr_valid); end
    #2 rst_n = 1'b1;
    step();
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL mr_init_req got=%0h want=0", bus.imem_req); end
    step();
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL mr_req_back got=%0h want=1", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL mr_restart_addr got=%0h want=0", bus.imem_addr); end
    step();
    total++; if (bus.instr_pc !== 32'h0) begin bad++; $display("FAIL mr_cap_pc got=%0h want=0", bus.instr_pc); end
    total++; if (bus.pc4 !== 32'h4) begin bad++; $display("FAIL mr_cap_pc4 got=%0h want=4", bus.pc4); end
    total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL mr_cap_valid got=%0h want=1", bus.instr_valid); end
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.jump = 1'b0;
    bus.jump_target = 32'h0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'h0;
    bus.imem_ready = 1'b0;
    bus2.stall = 1'b0;
    bus2.jump = 1'b0;
    bus2.jump_target = 32'h0;
    bus2.branch_taken = 1'b0;
    bus2.branch_target = 32'h0;
    bus2.imem_ready = 1'b0;
    test_reset();
    test_sequential();
    test_wait_ready();
    test_redirect();
    test_stall();
    test_redirect_stall();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, is the PC value loaded on reset; bits [1:0] SHALL be 00.
REQ-002 clk  input  1  single clock for the block; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 stall  input  1  pipeline hold request from downstream.
REQ-005 jump  input  1  redirect to jump_target this cycle.
REQ-006 jump_target  input  32  jump destination; bits [1:0] ignored and treated as 00.
REQ-007 branch_taken  input  1  redirect to branch_target this cycle.
REQ-008 branch_target  input  32  branch destination; bits [1:0] ignored and treated as 00.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address, equal to the current PC.
REQ-011 imem_ready  input  1  memory accepts and returns data this cycle.
REQ-012 imem_rdata  input  32  instruction word, valid when imem_req && imem_ready.
REQ-013 instr_valid  output  1  instr/instr_pc/pc4 hold a fetched, non-squashed instruction.
REQ-014 instr  output  32  captured instruction word.
REQ-015 instr_pc  output  32  address the instruction was fetched from.
REQ-016 pc4  output  32  instr_pc + 4, modulo 2^32.

Function
REQ-017 FSM states: INIT, FETCH, HOLD; the state after reset SHALL be INIT.
REQ-018 INIT SHALL last exactly one cycle with imem_req=0, then go to FETCH.
REQ-019 In FETCH, imem_req=1 and imem_addr=PC; if stall=1, the FSM SHALL go to HOLD with imem_req=0 from the next cycle.
REQ-020 A handshake is imem_req && imem_ready at a rising edge; it SHALL capture instr<=imem_rdata, instr_pc<=PC, pc4<=PC+4, instr_valid<=1, and PC<=PC+4.
REQ-021 The fetch latency SHALL be one cycle: captured outputs are visible the cycle after the handshake.
REQ-022 In FETCH with no handshake and no redirect, PC, instr, instr_pc and pc4 SHALL hold, and instr_valid SHALL go to 0 at the next edge.
REQ-023 In HOLD, imem_req=0, and PC, instr, instr_pc, pc4 and instr_valid SHALL hold; when stall=0 the FSM SHALL return to FETCH.
REQ-024 Redirect priority SHALL be jump > branch_taken > sequential.
REQ-025 A redirect in any state except INIT SHALL load PC with the selected target, force instr_valid to 0, and discard any same-cycle handshake data.
REQ-026 A redirect SHALL override stall; the FSM SHALL go to FETCH, or to HOLD if stall=1.
REQ-027 PC increments SHALL wrap modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000, for both PC and pc4.
REQ-028 imem_addr[1:0] SHALL always be 00.
REQ-029 imem_req and imem_addr SHALL depend only on registered state, with no combinational path from inputs.

Reset
REQ-030 On rst_n=0, immediately and regardless of clk, the block SHALL set: PC=RESET_PC, state=INIT, imem_req=0, instr_valid=0, instr=0, instr_pc=0, pc4=0.
REQ-031 Reset asserted mid-transaction SHALL abandon the fetch; no capture occurs.
REQ-032 Reset release SHALL be sampled on a clk rising edge; the first imem_req SHALL be asserted on the second edge after release.

Verification
REQ-033 Reset, then imem_ready=1 constantly with rdata = address -> imem_addr sequence 0,4,8,12; instr_pc/pc4 pairs (0,4),(4,8); instr_valid high every cycle after the first handshake.
REQ-034 PC=100 with imem_ready low for 3 cycles -> imem_addr stays 100, instr_valid=0 during the wait; on ready, instr_pc=100 and pc4=104.
REQ-035 jump=1 with jump_target=32'h00400003 and branch_taken=1 in the same cycle as a handshake -> next imem_addr=32'h00400000, instr_valid=0 next cycle.
REQ-036 stall=1 for 4 cycles after fetching 8 -> imem_req=0, instr_pc=8 held and instr_valid held at 1; after release, fetch resumes at 12.
REQ-037 RESET_PC=32'hFFFFFFFC with ready=1 -> first capture gives instr_pc=FFFFFFFC and pc4=00000000; next imem_addr=0.
REQ-038 rst_n pulsed low between clock edges while imem_ready=1 -> outputs clear immediately, no capture, and the fetch restarts at RESET_PC.
